// File: rtl/msrv32_csr_file.sv
// Machine-mode CSR file for the msrv32 core: status/trap registers,
// 64-bit cycle/instret counters, and trap/mret sequencing.
module msrv32_csr_file #(
    parameter logic [31:0] MHARTID     = 32'h00000000,
    parameter logic [31:0] MTVEC_RESET = 32'h00000000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic        csr_wr_en_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_in,
    input  logic        instret_inc_in,
    input  logic        trap_in,
    input  logic [31:0] trap_cause_in,
    input  logic [31:0] trap_val_in,
    input  logic        mret_in,
    output logic [31:0] csr_data_out,
    output logic [31:0] trap_vector_out,
    output logic [31:0] epc_out,
    output logic        mie_out,
    output logic        illegal_csr_out
);

    localparam logic [11:0] A_MSTATUS   = 12'h300, A_MISA     = 12'h301, A_MIE     = 12'h304,
                            A_MTVEC     = 12'h305, A_MSCRATCH = 12'h340, A_MEPC    = 12'h341,
                            A_MCAUSE    = 12'h342, A_MTVAL    = 12'h343, A_MIP     = 12'h344,
                            A_MCYCLE    = 12'hB00, A_MCYCLEH  = 12'hB80, A_MINSTRET = 12'hB02,
                            A_MINSTRETH = 12'hB82, A_CYCLE    = 12'hC00, A_CYCLEH  = 12'hC80,
                            A_INSTRET   = 12'hC02, A_INSTRETH = 12'hC82, A_MHARTID = 12'hF14;
    localparam logic [31:0] MIE_MASK = 32'h00000888;

    logic        mstatus_mie, mstatus_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0] mcycle_q, minstret_q;
    logic        cnt_en_q;

    logic        mapped, ro_space, write_type, wr_commit, sys_wr;
    logic [31:0] operand, wr_val;

    wire unused_imm = &{1'b0, imm_in[31:5]};

    always_comb begin
        mapped       = 1'b1;
        csr_data_out = 32'h0;
        case (csr_addr_in)
            A_MSTATUS:                csr_data_out = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            A_MISA:                   csr_data_out = 32'h40000100;
            A_MIE:                    csr_data_out = mie_q;
            A_MTVEC:                  csr_data_out = mtvec_q;
            A_MSCRATCH:               csr_data_out = mscratch_q;
            A_MEPC:                   csr_data_out = mepc_q;
            A_MCAUSE:                 csr_data_out = mcause_q;
            A_MTVAL:                  csr_data_out = mtval_q;
            A_MIP:                    csr_data_out = 32'h0;
            A_MCYCLE, A_CYCLE:        csr_data_out = mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH:      csr_data_out = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:    csr_data_out = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH:  csr_data_out = minstret_q[63:32];
            A_MHARTID:                csr_data_out = MHARTID;
            default:                  mapped = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it stays legal on read-only CSRs.
    always_comb begin
        operand = csr_op_in[2] ? {27'b0, imm_in[4:0]} : rs1_in;
        case (csr_op_in[1:0])
            2'b01:   wr_val = operand;
            2'b10:   wr_val = csr_data_out | operand;
            2'b11:   wr_val = csr_data_out & ~operand;
            default: wr_val = csr_data_out;
        endcase
        write_type      = (csr_op_in[1:0] == 2'b01) || (csr_op_in[1:0] != 2'b00 && operand != 32'h0);
        ro_space        = (csr_addr_in[11:10] == 2'b11);
        illegal_csr_out = csr_wr_en_in && (!mapped || (ro_space && write_type));
        wr_commit       = csr_wr_en_in && (csr_op_in[1:0] != 2'b00) && mapped && !ro_space;
        sys_wr          = wr_commit && !trap_in && !mret_in;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mepc_q       <= 32'h0;
            mcause_q     <= 32'h0;
            mtval_q      <= 32'h0;
        end else if (trap_in) begin
            mepc_q       <= pc_in & ~32'h3;
            mcause_q     <= trap_cause_in;
            mtval_q      <= trap_val_in;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_in) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (sys_wr) begin
            case (csr_addr_in)
                A_MSTATUS: begin
                    mstatus_mie  <= wr_val[3];
                    mstatus_mpie <= wr_val[7];
                end
                A_MEPC:   mepc_q   <= wr_val & ~32'h3;
                A_MCAUSE: mcause_q <= wr_val;
                A_MTVAL:  mtval_q  <= wr_val;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'h0;
        end else if (wr_commit) begin
            case (csr_addr_in)
                A_MIE:      mie_q      <= wr_val & MIE_MASK;
                A_MTVEC:    mtvec_q    <= wr_val & ~32'h3;
                A_MSCRATCH: mscratch_q <= wr_val;
                default:    ;
            endcase
        end
    end

    // cnt_en_q holds mcycle for the first edge after reset release.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cnt_en_q   <= 1'b0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            cnt_en_q <= 1'b1;
            if (wr_commit && csr_addr_in == A_MCYCLE)        mcycle_q[31:0]  <= wr_val;
            else if (wr_commit && csr_addr_in == A_MCYCLEH)  mcycle_q[63:32] <= wr_val;
            else if (cnt_en_q)                               mcycle_q        <= mcycle_q + 64'd1;

            if (wr_commit && csr_addr_in == A_MINSTRET)       minstret_q[31:0]  <= wr_val;
            else if (wr_commit && csr_addr_in == A_MINSTRETH) minstret_q[63:32] <= wr_val;
            else if (instret_inc_in)                          minstret_q        <= minstret_q + 64'd1;
        end
    end

    assign trap_vector_out = mtvec_q;
    assign epc_out         = mepc_q;
    assign mie_out         = mstatus_mie;

endmodule

// File: tb/tb_msrv32_csr_file.sv
// Directed bench for msrv32_csr_file with hand-computed expectations.
module tb_msrv32_csr_file;
    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [11:0] csr_addr_in;
    logic [2:0]  csr_op_in;
    logic        csr_wr_en_in;
    logic [31:0] rs1_in, imm_in, pc_in;
    logic        instret_inc_in, trap_in, mret_in;
    logic [31:0] trap_cause_in, trap_val_in;
    logic [31:0] csr_data_out, trap_vector_out, epc_out;
    logic        mie_out, illegal_csr_out;

    int checks = 0;
    int errors = 0;

    msrv32_csr_file dut (
        .clk_in(clk_in), .reset_in(reset_in), .csr_addr_in(csr_addr_in), .csr_op_in(csr_op_in),
        .csr_wr_en_in(csr_wr_en_in), .rs1_in(rs1_in), .imm_in(imm_in), .pc_in(pc_in),
        .instret_inc_in(instret_inc_in), .trap_in(trap_in), .trap_cause_in(trap_cause_in),
        .trap_val_in(trap_val_in), .mret_in(mret_in), .csr_data_out(csr_data_out),
        .trap_vector_out(trap_vector_out), .epc_out(epc_out), .mie_out(mie_out),
        .illegal_csr_out(illegal_csr_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic csr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] r,
                       input logic [31:0] z, input logic en);
        csr_addr_in = a; csr_op_in = op; rs1_in = r; imm_in = z; csr_wr_en_in = en;
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
        csr(a, 3'b000, 32'h0, 32'h0, 1'b0);
        chk(tag, csr_data_out, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        reset_in = 1'b1; instret_inc_in = 1'b0; trap_in = 1'b0; mret_in = 1'b0;
        pc_in = 32'h0; trap_cause_in = 32'h0; trap_val_in = 32'h0;
        csr(12'h000, 3'b000, 32'h0, 32'h0, 1'b0);
        tick(); tick();
        rd(12'h300, "rst_mstatus", 32'h00001800);
        rd(12'hB00, "rst_mcycle", 32'h0);
        chk("rst_tvec", trap_vector_out, 32'h0);
        chk("rst_epc", epc_out, 32'h0);
        chk("rst_mie", {31'b0, mie_out}, 32'h0);

        reset_in = 1'b0;
        tick(); rd(12'hB00, "mcycle_edge1", 32'h0);
        tick(); rd(12'hB00, "mcycle_edge2", 32'h1);
        rd(12'hF14, "mhartid", 32'h0);
        rd(12'h301, "misa", 32'h40000100);
        rd(12'h344, "mip", 32'h0);

        // CSRRW then CSRRS on mscratch
        csr(12'h340, 3'b001, 32'hDEADBEEF, 32'h0, 1'b1);
        chk("rw_old", csr_data_out, 32'h0);
        tick();
        csr(12'h340, 3'b010, 32'h000000F0, 32'h0, 1'b1);
        chk("rs_old", csr_data_out, 32'hDEADBEEF);
        tick();
        rd(12'h340, "mscratch", 32'hDEADBEFF);

        // CSRRWI mtvec, low bits forced to zero
        csr(12'h305, 3'b101, 32'h0, 32'h0000001F, 1'b1);
        tick();
        csr(12'h000, 3'b000, 32'h0, 32'h0, 1'b0);
        chk("tvec_out", trap_vector_out, 32'h0000001C);
        rd(12'h305, "mtvec", 32'h0000001C);

        // mie writable mask
        csr(12'h304, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1);
        tick();
        rd(12'h304, "mie_mask", 32'h00000888);

        // trap beats simultaneous mepc write, then mret
        csr(12'h300, 3'b001, 32'h00000008, 32'h0, 1'b1);
        tick();
        chk("mie_set", {31'b0, mie_out}, 32'h1);
        trap_in = 1'b1; pc_in = 32'h00000102; trap_cause_in = 32'h2; trap_val_in = 32'h13;
        csr(12'h341, 3'b001, 32'h00000055, 32'h0, 1'b1);
        tick();
        trap_in = 1'b0;
        rd(12'h341, "trap_mepc", 32'h00000100);
        chk("trap_epc_out", epc_out, 32'h00000100);
        rd(12'h342, "trap_mcause", 32'h2);
        rd(12'h343, "trap_mtval", 32'h13);
        rd(12'h300, "trap_mstatus", 32'h00001880);
        chk("trap_mie_out", {31'b0, mie_out}, 32'h0);
        mret_in = 1'b1;
        tick();
        mret_in = 1'b0;
        rd(12'h300, "mret_mstatus", 32'h00001888);
        chk("mret_mie_out", {31'b0, mie_out}, 32'h1);

        // mcycle carry into high half
        csr(12'hB00, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1);
        tick();
        rd(12'hB00, "mcyc_lo_load", 32'hFFFFFFFF);
        csr(12'hB80, 3'b001, 32'h0, 32'h0, 1'b1);
        tick();
        rd(12'hB80, "mcyc_hi_load", 32'h0);
        rd(12'hB00, "mcyc_lo_held", 32'hFFFFFFFF);
        tick();
        rd(12'hB80, "mcyc_hi_carry", 32'h1);
        rd(12'hB00, "mcyc_lo_wrap", 32'h0);
        rd(12'hC80, "cycleh_mirror", 32'h1);

        // read-only space and unmapped accesses
        csr(12'hC00, 3'b001, 32'h5, 32'h0, 1'b1);
        chk("ill_rw_cycle", {31'b0, illegal_csr_out}, 32'h1);
        tick();
        rd(12'hC00, "cycle_unchanged", 32'h1);
        csr(12'h7C0, 3'b010, 32'h1, 32'h0, 1'b1);
        chk("ill_unmapped", {31'b0, illegal_csr_out}, 32'h1);
        chk("unmapped_rd", csr_data_out, 32'h0);
        tick();
        csr(12'hC00, 3'b010, 32'h0, 32'h0, 1'b1);
        chk("legal_rs_x0", {31'b0, illegal_csr_out}, 32'h0);
        chk("rs_x0_cycle", csr_data_out, 32'h2);
        rd(12'h340, "mscratch_kept", 32'hDEADBEFF);

        // minstret counting, write suppresses increment
        csr(12'hB02, 3'b001, 32'h5, 32'h0, 1'b1);
        tick();
        rd(12'hB02, "minstret_load", 32'h5);
        instret_inc_in = 1'b1;
        tick();
        instret_inc_in = 1'b0;
        rd(12'hC02, "instret_inc", 32'h6);
        instret_inc_in = 1'b1;
        csr(12'hB02, 3'b001, 32'h5, 32'h0, 1'b1);
        tick();
        instret_inc_in = 1'b0;
        rd(12'hB02, "minstret_wr_wins", 32'h5);

        // asynchronous reset mid-cycle
        #2;
        reset_in = 1'b1;
        #1;
        rd(12'hB02, "async_minstret", 32'h0);
        chk("async_mie_out", {31'b0, mie_out}, 32'h0);
        chk("async_epc", epc_out, 32'h0);
        rd(12'h300, "async_mstatus", 32'h00001800);

        // traffic during reset is discarded
        trap_in = 1'b1; pc_in = 32'h00000200;
        csr(12'h340, 3'b001, 32'h00001234, 32'h0, 1'b1);
        tick();
        trap_in = 1'b0;
        csr(12'h000, 3'b000, 32'h0, 32'h0, 1'b0);
        reset_in = 1'b0;
        rd(12'h340, "rst_discard_wr", 32'h0);
        chk("rst_discard_trap", epc_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
